// File: rtl/unit_pkt_dispatch_pkg.sv
// Shared definitions for the packet dispatcher.
//   - Packet type field width and the two legal header type codes.
//   - Default unit bus width.
//   - FSM state encoding and an index-width helper.
package unit_pkt_dispatch_pkg;

  localparam int unsigned UNIT_INPUT_WIDTH = 16;

  // Header type lives in the low bits of a ctrl word.
  localparam int unsigned PKT_TYPE_W = 3;
  localparam logic [PKT_TYPE_W-1:0] PKT_TYPE_DATA     = 3'd0;
  localparam logic [PKT_TYPE_W-1:0] PKT_TYPE_ENTRY_PT = 3'd1;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StStream,
    StBcastWait,
    StBcast,
    StDiscard,
    StGuard
  } state_e;

  // Width needed to index n items; never zero.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/unit_pkt_dispatch_rr_select.sv
// Combinational round-robin pick over the unit ready vector.
// Ports:
//   ready  in   N_UNITS  per-unit ready
//   ptr    in   IDX_W    first index to consider
//   idx    out  IDX_W    first ready unit at or after ptr (with wrap)
//   found  out  1        some unit is ready
module unit_pkt_dispatch_rr_select
  import unit_pkt_dispatch_pkg::*;
#(
  parameter int unsigned N_UNITS = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [N_UNITS-1:0] ready,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  always_comb begin
    int unsigned j;
    j     = 0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      j = 32'(ptr) + i;
      if (j >= N_UNITS) j = j - N_UNITS;
      if (!found && ready[IDX_W'(j)]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/unit_pkt_dispatch.sv
// Packet dispatcher between the host FWFT FIFO and the per-unit input stages.
// Data packets (type 0) go to one ready unit chosen round-robin; entry-point
// packets (type 1) are broadcast to all units; anything else is dropped and
// flagged.
// Ports:
//   CLK, reset                      clock, synchronous active-high reset
//   in_data, in_ctrl, in_empty      FIFO head word, framing flag, empty
//   in_rd_en                        FIFO pop (combinational)
//   out_data, out_ctrl, unit_wr_en  registered unit write bus
//   unit_afull, unit_ready          per-unit flow control
//   idle                            registered: idle with nothing queued
//   err_pkt_type, err_pkt_len       sticky error flags
module unit_pkt_dispatch
  import unit_pkt_dispatch_pkg::*;
#(
  parameter int unsigned N_UNITS       = 4,
  parameter int unsigned INPUT_WIDTH   = UNIT_INPUT_WIDTH,
  parameter int unsigned INPUT_N_WORDS = 128,
  parameter int unsigned GUARD_CYCLES  = 2   // must be at least 1
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [INPUT_WIDTH-1:0] in_data,
  input  logic                   in_ctrl,
  input  logic                   in_empty,
  output logic                   in_rd_en,
  output logic [INPUT_WIDTH-1:0] out_data,
  output logic                   out_ctrl,
  output logic [N_UNITS-1:0]     unit_wr_en,
  input  logic [N_UNITS-1:0]     unit_afull,
  input  logic [N_UNITS-1:0]     unit_ready,
  output logic                   idle,
  output logic                   err_pkt_type,
  output logic                   err_pkt_len
);

  localparam int unsigned IDX_W = idx_width(N_UNITS);
  localparam int unsigned CNT_W = $clog2(INPUT_N_WORDS + 1);
  localparam int unsigned GRD_W = idx_width(GUARD_CYCLES);

  localparam logic [IDX_W-1:0] LAST_UNIT  = IDX_W'(N_UNITS - 1);
  localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(INPUT_N_WORDS - 1);
  localparam logic [GRD_W-1:0] GUARD_LAST = GRD_W'(GUARD_CYCLES - 1);

  state_e                  state;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        target;
  logic [CNT_W-1:0]        word_cnt;
  logic [GRD_W-1:0]        guard_cnt;
  // Header of the current packet is still at the FIFO head.
  logic                    hdr_pending;

  logic [PKT_TYPE_W-1:0]   hdr_type;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_found;
  logic [N_UNITS-1:0]      target_mask;
  logic [IDX_W-1:0]        next_ptr;

  assign hdr_type = in_data[PKT_TYPE_W-1:0];

  unit_pkt_dispatch_rr_select #(
    .N_UNITS (N_UNITS),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .ready (unit_ready),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    target_mask         = '0;
    target_mask[target] = 1'b1;
    next_ptr            = (target == LAST_UNIT) ? '0 : target + 1'b1;
  end

  // Pops are gated only by FIFO occupancy and the afull of whoever is targeted,
  // so a stalled unit stops the stream in the same cycle without losing words.
  always_comb begin
    in_rd_en = 1'b0;
    case (state)
      StIdle:    in_rd_en = !in_empty && !in_ctrl;
      StStream:  in_rd_en = !in_empty && !unit_afull[target];
      StBcast:   in_rd_en = !in_empty && ~|unit_afull;
      StDiscard: in_rd_en = !in_empty;
      default:   in_rd_en = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state        <= StIdle;
      rr_ptr       <= '0;
      target       <= '0;
      word_cnt     <= '0;
      guard_cnt    <= '0;
      hdr_pending  <= 1'b0;
      out_data     <= '0;
      out_ctrl     <= 1'b0;
      unit_wr_en   <= '0;
      idle         <= 1'b1;
      err_pkt_type <= 1'b0;
      err_pkt_len  <= 1'b0;
    end else begin
      unit_wr_en <= '0;
      out_ctrl   <= 1'b0;
      idle       <= (state == StIdle) && in_empty;

      case (state)
        StIdle: begin
          if (!in_empty) begin
            if (!in_ctrl) begin
              // Stray body word outside any packet; popped by in_rd_en.
              err_pkt_type <= 1'b1;
            end else if (hdr_type == PKT_TYPE_DATA) begin
              state <= StSelect;
            end else if (hdr_type == PKT_TYPE_ENTRY_PT) begin
              state <= StBcastWait;
            end else begin
              err_pkt_type <= 1'b1;
              hdr_pending  <= 1'b1;
              state        <= StDiscard;
            end
          end
        end

        StSelect: begin
          if (pick_found) begin
            target      <= pick_idx;
            word_cnt    <= '0;
            hdr_pending <= 1'b1;
            state       <= StStream;
          end
        end

        StStream: begin
          if (in_rd_en) begin
            out_data   <= in_data;
            out_ctrl   <= in_ctrl;
            unit_wr_en <= target_mask;
            if (hdr_pending) begin
              hdr_pending <= 1'b0;
            end else if (in_ctrl) begin
              rr_ptr    <= next_ptr;
              guard_cnt <= '0;
              state     <= StGuard;
            end else if (word_cnt == LAST_WORD) begin
              // Unit buffer is full: close the packet here, drop the rest.
              out_ctrl    <= 1'b1;
              err_pkt_len <= 1'b1;
              rr_ptr      <= next_ptr;
              state       <= StDiscard;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end

        StBcastWait: begin
          if (&unit_ready && ~|unit_afull) begin
            hdr_pending <= 1'b1;
            state       <= StBcast;
          end
        end

        StBcast: begin
          if (in_rd_en) begin
            out_data   <= in_data;
            out_ctrl   <= in_ctrl;
            unit_wr_en <= '1;
            if (hdr_pending) begin
              hdr_pending <= 1'b0;
            end else if (in_ctrl) begin
              guard_cnt <= '0;
              state     <= StGuard;
            end
          end
        end

        StDiscard: begin
          if (in_rd_en) begin
            hdr_pending <= 1'b0;
            if (in_ctrl && !hdr_pending) state <= StIdle;
          end
        end

        StGuard: begin
          // Gives a just-loaded unit time to drop ready before the next pick.
          if (guard_cnt == GUARD_LAST) state <= StIdle;
          else guard_cnt <= guard_cnt + 1'b1;
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_unit_pkt_dispatch.sv
// Self-checking bench for unit_pkt_dispatch: directed scenarios followed by
// randomized packets, all checked against a packet-level reference model.
module tb_unit_pkt_dispatch;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int NW = 128;
  localparam int GC = 2;
  localparam int IW = 2;

  logic         CLK = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_ctrl;
  logic         in_empty;
  logic         in_rd_en;
  logic [W-1:0] out_data;
  logic         out_ctrl;
  logic [N-1:0] unit_wr_en;
  logic [N-1:0] unit_afull;
  logic [N-1:0] unit_ready;
  logic         idle;
  logic         err_pkt_type;
  logic         err_pkt_len;

  always #5 CLK = ~CLK;

  unit_pkt_dispatch #(
    .N_UNITS       (N),
    .INPUT_WIDTH   (W),
    .INPUT_N_WORDS (NW),
    .GUARD_CYCLES  (GC)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .in_data      (in_data),
    .in_ctrl      (in_ctrl),
    .in_empty     (in_empty),
    .in_rd_en     (in_rd_en),
    .out_data     (out_data),
    .out_ctrl     (out_ctrl),
    .unit_wr_en   (unit_wr_en),
    .unit_afull   (unit_afull),
    .unit_ready   (unit_ready),
    .idle         (idle),
    .err_pkt_type (err_pkt_type),
    .err_pkt_len  (err_pkt_len)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [W:0]   fifo[$];    // {ctrl, data}
  logic [W:0]   pkt[$];     // packet under construction
  logic [N+W:0] exp_wr[$];  // {wr_en, ctrl, data}
  int           rr_ptr_m;
  int           last_target;
  logic         exp_err_type;
  logic         exp_err_len;
  logic [N-1:0] cur_mask;
  logic         hold_empty;
  logic         rand_mode;
  logic         rd_seen;
  logic [W:0]   popped;
  int           wr_count;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expd);
    n_checks++;
    if (obs !== expd) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expd);
    end
  endtask

  task automatic drive_head();
    in_empty = (fifo.size() == 0) || hold_empty;
    if (fifo.size() != 0) {in_ctrl, in_data} = fifo[0];
    else {in_ctrl, in_data} = '0;
  endtask

  // One clock: sample the pop decision at the edge, apply it and check the
  // registered outputs half a cycle later.
  task automatic step();
    logic [N+W:0] e;
    @(posedge CLK);
    rd_seen = in_rd_en && !reset;
    if (rd_seen) begin
      check_eq("rd_when_empty", 64'(in_empty), 64'd0);
      check_eq("rd_when_afull", 64'(unit_afull & cur_mask), 64'd0);
      if (fifo.size() != 0) popped = fifo.pop_front();
    end
    @(negedge CLK);
    if (!reset && unit_wr_en != '0) begin
      wr_count++;
      check_eq("latency", 64'({rd_seen, out_data}), 64'({1'b1, popped[W-1:0]}));
      if (exp_wr.size() == 0) begin
        check_eq("unexpected_wr", 64'({unit_wr_en, out_ctrl, out_data}), 64'd0);
      end else begin
        e = exp_wr.pop_front();
        check_eq("wr", 64'({unit_wr_en, out_ctrl, out_data}), 64'(e));
      end
    end
    if (rand_mode) begin
      unit_afull = ($urandom_range(3) == 0) ? N'($urandom) : '0;
      hold_empty = ($urandom_range(5) == 0);
    end
    drive_head();
  endtask

  function automatic int pick(input logic [N-1:0] rdy, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (rdy[IW'((ptr + i) % N)]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic add(input logic c, input logic [W-1:0] d);
    pkt.push_back({c, d});
  endtask

  // Packet-level model: which writes the packet in pkt must produce.
  task automatic expect_pkt();
    logic [N-1:0] m;
    logic [2:0]   typ;
    logic [W:0]   w;
    int           t;
    w   = pkt[0];
    typ = w[2:0];
    if (!w[W]) begin
      exp_err_type = 1'b1;
      cur_mask     = '0;
    end else if (typ == 3'd0) begin
      t = pick(unit_ready, rr_ptr_m);
      if (t < 0) t = 0;
      last_target  = t;
      m            = '0;
      m[IW'(t)]    = 1'b1;
      cur_mask     = m;
      exp_wr.push_back({m, 1'b1, w[W-1:0]});
      for (int k = 1; k < pkt.size(); k++) begin
        w = pkt[k];
        if (w[W]) begin
          exp_wr.push_back({m, 1'b1, w[W-1:0]});
          break;
        end
        if (k == NW) begin
          exp_wr.push_back({m, 1'b1, w[W-1:0]});
          exp_err_len = 1'b1;
          break;
        end
        exp_wr.push_back({m, 1'b0, w[W-1:0]});
      end
      rr_ptr_m = (t + 1) % N;
    end else if (typ == 3'd1) begin
      cur_mask = '1;
      exp_wr.push_back({{N{1'b1}}, 1'b1, w[W-1:0]});
      for (int k = 1; k < pkt.size(); k++) begin
        w = pkt[k];
        exp_wr.push_back({{N{1'b1}}, w[W], w[W-1:0]});
        if (w[W]) break;
      end
    end else begin
      exp_err_type = 1'b1;
      cur_mask     = '0;
    end
  endtask

  task automatic push_only();
    foreach (pkt[i]) fifo.push_back(pkt[i]);
    drive_head();
  endtask

  task automatic send();
    expect_pkt();
    push_only();
    pkt.delete();
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((fifo.size() != 0 || exp_wr.size() != 0) && n < 3000) begin
      step();
      n++;
    end
    check_eq({tag, "_drain"}, 64'(fifo.size() + exp_wr.size()), 64'd0);
    repeat (GC + 3) step();
    check_eq({tag, "_err_type"}, 64'(err_pkt_type), 64'(exp_err_type));
    check_eq({tag, "_err_len"}, 64'(err_pkt_len), 64'(exp_err_len));
    check_eq({tag, "_idle"}, 64'(idle), 64'd1);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    hold_empty = 1'b0;
    unit_afull = '0;
    fifo.delete();
    exp_wr.delete();
    pkt.delete();
    drive_head();
    repeat (3) step();
    reset        = 1'b0;
    rr_ptr_m     = 0;
    exp_err_type = 1'b0;
    exp_err_len  = 1'b0;
    cur_mask     = '0;
  endtask

  initial begin
    int base;
    int n;
    reset      = 1'b1;
    unit_ready = '1;
    unit_afull = '0;
    hold_empty = 1'b0;
    rand_mode  = 1'b0;
    wr_count   = 0;
    popped     = '0;
    drive_head();
    do_reset();

    // Reset state
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    check_eq("rst_wr_en", 64'(unit_wr_en), 64'd0);
    check_eq("rst_err", 64'({err_pkt_type, err_pkt_len}), 64'd0);
    check_eq("rst_idle", 64'(idle), 64'd1);
    check_eq("rst_rd_en", 64'(in_rd_en), 64'd0);

    // 1: two identical data packets land on units 0 then 1
    unit_ready = '1;
    for (int p = 0; p < 2; p++) begin
      add(1'b1, 16'h0000); add(1'b0, 16'h1111); add(1'b0, 16'h2222); add(1'b1, 16'h3333);
      send();
    end
    wait_done("t1");

    // 2: ready 1010 picks unit 1; nobody ready stalls SELECT; then unit 3
    do_reset();
    unit_ready = 4'b1010;
    add(1'b1, 16'h0000); add(1'b0, 16'hA001); add(1'b1, 16'hA002);
    send();
    wait_done("t2a");
    unit_ready = 4'b0000;
    add(1'b1, 16'h0100); add(1'b0, 16'hB001); add(1'b1, 16'hB002);
    push_only();
    for (int i = 0; i < 12; i++) begin
      step();
      check_eq("select_wait_rd", 64'(rd_seen), 64'd0);
    end
    unit_ready = 4'b1000;
    expect_pkt();
    pkt.delete();
    wait_done("t2b");

    // 3: entry-point broadcast, then one that waits for unit 2
    unit_ready = '1;
    add(1'b1, 16'((5 << 3) | 1)); add(1'b1, 16'hABCD);
    send();
    wait_done("t3a");
    unit_ready = 4'b1011;
    add(1'b1, 16'((7 << 3) | 1)); add(1'b1, 16'h5A5A);
    push_only();
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("bcast_wait_rd", 64'(rd_seen), 64'd0);
    end
    unit_ready = '1;
    expect_pkt();
    pkt.delete();
    wait_done("t3b");

    // 4: target afull for three cycles mid-packet
    add(1'b1, 16'h0008);
    for (int i = 0; i < 8; i++) add(1'b0, 16'(16'hC000 + i));
    add(1'b1, 16'hC0FF);
    send();
    base = wr_count;
    n = 0;
    while (wr_count < base + 3 && n < 50) begin
      step();
      n++;
    end
    unit_afull = '1;
    unit_afull[IW'(last_target)] = 1'b0;
    step();
    check_eq("afull_other_rd", 64'(rd_seen), 64'd1);
    unit_afull = '0;
    unit_afull[IW'(last_target)] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("afull_stall_rd", 64'(rd_seen), 64'd0);
    end
    unit_afull = '0;
    step();
    check_eq("afull_resume_rd", 64'(rd_seen), 64'd1);
    wait_done("t4");

    // 5: stray body word, then a bad type, then a good packet
    do_reset();
    add(1'b0, 16'h7777);
    send();
    wait_done("t5a");
    do_reset();
    add(1'b1, 16'h0005); add(1'b0, 16'h0123); add(1'b1, 16'h0456);
    send();
    wait_done("t5b");
    add(1'b1, 16'h0000); add(1'b0, 16'hD001); add(1'b1, 16'hD002);
    send();
    wait_done("t5c");

    // 6: overflow closes the packet at word NW and drops the tail
    do_reset();
    add(1'b1, 16'h0000);
    for (int i = 1; i <= 130; i++) add(1'b0, 16'(i));
    add(1'b1, 16'hEEEE);
    send();
    wait_done("t6");

    // Randomized traffic with random afull and FIFO gaps
    do_reset();
    rand_mode = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int kind;
      int len;
      kind = int'($urandom_range(9));
      len  = int'($urandom_range(8));
      if (kind <= 5) begin
        unit_ready = N'($urandom_range(15, 1));
        add(1'b1, {13'($urandom), 3'd0});
        for (int i = 0; i < len; i++) add(1'b0, W'($urandom));
        add(1'b1, W'($urandom));
      end else if (kind <= 7) begin
        unit_ready = '1;
        add(1'b1, {13'($urandom), 3'd1});
        add(1'b1, W'($urandom));
      end else if (kind == 8) begin
        add(1'b1, {13'($urandom), 3'($urandom_range(7, 2))});
        for (int i = 0; i < len; i++) add(1'b0, W'($urandom));
        add(1'b1, W'($urandom));
      end else begin
        add(1'b0, W'($urandom));
      end
      send();
      wait_done("rnd");
    end
    rand_mode  = 1'b0;
    unit_afull = '0;
    hold_empty = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/unit_pkt_dispatch.md
Name: unit_pkt_dispatch

Overview:
Single-clock packet dispatcher that sits directly upstream of the per-unit async input stages. It reads framed packets from the host-side FWFT FIFO and steers each data packet (type 0) to one idle unit, chosen round-robin. It broadcasts entry-point packets (type 1) to all units. It discards malformed packets and flags them. It drives each unit's write side (in, ctrl, wr_en) and honours that unit's afull and ready.

Parameters:
N_UNITS, 4, number of downstream units; unit index width is `MSB(N_UNITS-1)+1.
INPUT_WIDTH, `UNIT_INPUT_WIDTH (16), word width of the FIFO and the unit bus.
INPUT_N_WORDS, 128, unit buffer depth in words; the maximum data words per packet, header excluded.
GUARD_CYCLES, 2, idle cycles after each packet end before the next selection.

Ports:
CLK  in  1  single clock; also the units' WR_CLK.
reset  in  1  synchronous, active-high.
in_data  in  INPUT_WIDTH  FWFT FIFO head word.
in_ctrl  in  1  framing flag of the head word.
in_empty  in  1  FIFO empty.
in_rd_en  out  1  FIFO pop; combinational.
out_data  out  INPUT_WIDTH  registered word bus shared by all units.
out_ctrl  out  1  registered framing flag.
unit_wr_en  out  N_UNITS  registered one-hot write enable; all ones on broadcast.
unit_afull  in  N_UNITS  per-unit almost-full.
unit_ready  in  N_UNITS  per-unit ready; 1 means the unit can accept a new packet.
idle  out  1  registered; 1 in IDLE with in_empty high.
err_pkt_type  out  1  sticky; set by a bad header type or a stray non-ctrl word.
err_pkt_len  out  1  sticky; set by data-packet overflow.

Behaviour:
- Reset values: in_rd_en, out_ctrl, unit_wr_en, err_* = 0. out_data = 0. idle = 1. rr_ptr = 0. State = IDLE. Reset mid-packet abandons the packet; the units are reset by the same system reset.
- Header word: in_ctrl=1. Type = in_data[2:0]. Type 0 = data. Type 1 = entry point, with the payload in the header's upper bits. Packet end = the next word with in_ctrl=1.
- Forwarding: a word popped in cycle t appears on out_data/out_ctrl/unit_wr_en in cycle t+1. Latency is one cycle.
- Pop rule: pop only when !in_empty and no targeted unit has afull=1. There are no bubbles otherwise.
- States:
  IDLE: the head word is examined without popping.
    !in_ctrl: pop and discard, set err_pkt_type, stay in IDLE.
    Type 0 -> SELECT.
    Type 1 -> BCAST_WAIT.
    Types 2..7 -> DISCARD.
  SELECT: search unit_ready from rr_ptr upward with wrap. First hit: latch target, go to STREAM. No hit: stay in SELECT.
  STREAM: forward the header, then the data words. A word with in_ctrl=1 that is not the header ends the packet. Set rr_ptr = target+1, with wrap to 0 at N_UNITS. Go to GUARD.
    Data-word counter is 8 bits for the default depth. If word number INPUT_N_WORDS is reached without ctrl, force out_ctrl=1 on that word, set err_pkt_len, go to DISCARD.
  BCAST_WAIT: wait until &unit_ready and ~|unit_afull, then go to BCAST.
  BCAST: forward header and end word with unit_wr_en all ones; afull is checked across all units. End word -> GUARD.
  DISCARD: pop every available word without forwarding. A word with ctrl (other than the entry header) -> IDLE.
  GUARD: GUARD_CYCLES cycles with no pops, then IDLE.
- Why GUARD exists: a unit deasserts ready one cycle after accepting a header, and the ready input may lag further. GUARD prevents reselecting a unit that is still busy.
- A unit with ready=0 never receives a header. Each packet goes to exactly one unit, and packets are never interleaved.
- Simultaneous events:
  afull asserts mid-packet: popping stalls that same cycle, with no word loss.
  in_empty mid-packet: output stalls and the state is held.
  All units busy: SELECT waits without limit; the FIFO is not popped.
- Error flags clear only on reset.

Decomposition:
- Shared md5.vh additions: packet type constants PKT_TYPE_DATA=0 and PKT_TYPE_ENTRY_PT=1; the PKT_TYPE field width (3).
- One sub-module: rr_select. Combinational round-robin priority pick over unit_ready starting at rr_ptr. Outputs the index and a found flag.

Test Plan:
1. All 4 units ready. Send data packet: header 0x0000, words 0x1111 and 0x2222, end 0x3333 with ctrl. Required: unit 0 gets 4 writes, ctrl=1 on the 1st and 4th, 1-cycle latency. The next identical packet goes to unit 1.
2. unit_ready=4'b1010, rr_ptr=0. Send a data packet -> unit 1 selected. Drop unit_ready to 4'b0000 -> the next packet waits in SELECT with in_rd_en=0. Raise bit 3 -> unit 3 gets the packet.
3. Entry packet: header (5<<3)|1, then end word with ctrl. Units 0-3 ready. Required: both words are written with unit_wr_en=4'b1111. If unit 2 has ready=0, nothing is written until it rises.
4. Target afull pulses for 3 cycles mid-packet -> in_rd_en=0 for exactly those cycles, and the output sequence is intact.
5. Header type 5 with 3 words -> all popped, no unit_wr_en, err_pkt_type=1. A following valid packet dispatches normally.
6. Data packet with 130 data words and no early ctrl -> word 128 is written with out_ctrl=1, err_pkt_len=1, the remaining 2 words are discarded, and the FSM returns to IDLE.
